// File: rtl/hue_seq_pkg.sv
// Shared types for the hue sequencer: colour-wheel segment encoding and
// the segment successor helper.
package hue_seq_pkg;

   typedef enum logic [2:0] {
      R_TO_Y = 3'd0,
      Y_TO_G = 3'd1,
      G_TO_C = 3'd2,
      C_TO_B = 3'd3,
      B_TO_M = 3'd4,
      M_TO_R = 3'd5
   } seg_t;

   localparam seg_t SEG_LAST = M_TO_R;

   function automatic seg_t seg_next(input seg_t s);
      return (s == SEG_LAST) ? R_TO_Y : seg_t'(s + 3'd1);
   endfunction

endpackage

// File: rtl/hue_sequencer_tick_prescaler.sv
// Run-gated clock divider: one tick every TICK_DIV run cycles, count held
// while run is low.
module tick_prescaler #(
   parameter int TICK_DIV = 1667
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (run) begin
         if (cnt_q == CW'(TICK_DIV - 1)) begin
            tick  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hue_sequencer.sv
// Six-segment RGB colour-wheel sequencer driving three PWM duty values.
// Optional endpoint dwell enabled by `define HUE_SEQUENCER_DWELL_EN.
module hue_sequencer
   import hue_seq_pkg::*;
#(
   parameter int PWM_INTERVAL = 1200,
   parameter int STEP         = 1,
   parameter int TICK_DIV     = 1667,
   parameter int DWELL_TICKS  = 300,
   localparam int W           = $clog2(PWM_INTERVAL + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   output logic [W-1:0] pwm_value_r,
   output logic [W-1:0] pwm_value_g,
   output logic [W-1:0] pwm_value_b,
   output logic [2:0]   segment,
   output logic         wrap,
   output logic         dwell
);

   localparam logic [W-1:0] FULL = W'(PWM_INTERVAL);

   logic         tick;
   seg_t         seg_q, seg_d;
   logic [W-1:0] ramp_q, ramp_d;
   logic [W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic         wrap_q, wrap_d;
   logic         dwell_q, dwell_d;
   logic         seg_end;
   logic [W-1:0] lvl, up, dn;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .tick (tick)
   );

   // Compared one bit wider so ramp+STEP cannot wrap past FULL.
   assign seg_end = ({1'b0, ramp_q} + (W+1)'(STEP)) >= (W+1)'(PWM_INTERVAL);

`ifdef HUE_SEQUENCER_DWELL_EN
   localparam int DCW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic           dwell_done;

   assign dwell_done = (dcnt_q == DCW'(DWELL_TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_q <= 1'b0;
         dcnt_q  <= '0;
      end else begin
         dwell_q <= dwell_d;
         dcnt_q  <= dcnt_d;
      end
   end
`else
   logic unused_dwell_cfg;
   assign unused_dwell_cfg = (DWELL_TICKS != 0);
   assign dwell_q          = 1'b0;
`endif

   always_comb begin
      seg_d   = seg_q;
      ramp_d  = ramp_q;
      wrap_d  = 1'b0;
      dwell_d = dwell_q;
`ifdef HUE_SEQUENCER_DWELL_EN
      dcnt_d  = dcnt_q;
`endif
      if (tick) begin
         if (dwell_q) begin
`ifdef HUE_SEQUENCER_DWELL_EN
            if (dwell_done) begin
               dwell_d = 1'b0;
               ramp_d  = '0;
               seg_d   = seg_next(seg_q);
               wrap_d  = (seg_q == SEG_LAST);
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
`endif
         end else if (seg_end) begin
`ifdef HUE_SEQUENCER_DWELL_EN
            dwell_d = 1'b1;
            dcnt_d  = '0;
`else
            ramp_d = '0;
            seg_d  = seg_next(seg_q);
            wrap_d = (seg_q == SEG_LAST);
`endif
         end else begin
            ramp_d = ramp_q + W'(STEP);
         end
      end
   end

   // Duties follow the next state; a dwelling segment shows its endpoint colour.
   assign lvl = dwell_d ? FULL : ramp_d;
   assign up  = lvl;
   assign dn  = FULL - lvl;

   always_comb begin
      r_d = FULL;
      g_d = '0;
      b_d = '0;
      case (seg_d)
         R_TO_Y:  begin r_d = FULL; g_d = up;   b_d = '0;   end
         Y_TO_G:  begin r_d = dn;   g_d = FULL; b_d = '0;   end
         G_TO_C:  begin r_d = '0;   g_d = FULL; b_d = up;   end
         C_TO_B:  begin r_d = '0;   g_d = dn;   b_d = FULL; end
         B_TO_M:  begin r_d = up;   g_d = '0;   b_d = FULL; end
         M_TO_R:  begin r_d = FULL; g_d = '0;   b_d = dn;   end
         default: begin r_d = FULL; g_d = '0;   b_d = '0;   end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q  <= R_TO_Y;
         ramp_q <= '0;
         r_q    <= FULL;
         g_q    <= '0;
         b_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         seg_q  <= seg_d;
         ramp_q <= ramp_d;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         wrap_q <= wrap_d;
      end
   end

   assign pwm_value_r = r_q;
   assign pwm_value_g = g_q;
   assign pwm_value_b = b_q;
   assign segment     = seg_q;
   assign wrap        = wrap_q;
   assign dwell       = dwell_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Randomized self-checking bench for hue_sequencer; the reference derives
// every output from the count of run cycles since reset.
module tb_hue_sequencer;

   localparam int F    = 12;
   localparam int STP  = 3;
   localparam int TDIV = 4;
   localparam int DT   = 2;
   localparam int W    = $clog2(F + 1);
   localparam int K    = (F + STP - 1) / STP;
`ifdef HUE_SEQUENCER_DWELL_EN
   localparam int P    = K + DT;
`else
   localparam int P    = K;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         run;
   logic [W-1:0] pwm_r, pwm_g, pwm_b;
   logic [2:0]   segment;
   logic         wrap;
   logic         dwell;

   int n_checks = 0;
   int n_fail   = 0;
   int run_cycles = 0;
   int prev_n     = 0;

   hue_sequencer #(
      .PWM_INTERVAL (F),
      .STEP         (STP),
      .TICK_DIV     (TDIV),
      .DWELL_TICKS  (DT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .pwm_value_r (pwm_r),
      .pwm_value_g (pwm_g),
      .pwm_value_b (pwm_b),
      .segment     (segment),
      .wrap        (wrap),
      .dwell       (dwell)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Ticks elapsed = run cycles / TICK_DIV; each segment spans P ticks.
   task automatic check_model();
      int n, pos, seg, lvl, er, eg, eb;
      bit in_dwell, ew;
      n        = run_cycles / TDIV;
      pos      = n % P;
      seg      = (n / P) % 6;
      in_dwell = (pos >= K);
      lvl      = in_dwell ? F : pos * STP;
      case (seg)
         0:       begin er = F;       eg = lvl;     eb = 0;       end
         1:       begin er = F - lvl; eg = F;       eb = 0;       end
         2:       begin er = 0;       eg = F;       eb = lvl;     end
         3:       begin er = 0;       eg = F - lvl; eb = F;       end
         4:       begin er = lvl;     eg = 0;       eb = F;       end
         default: begin er = F;       eg = 0;       eb = F - lvl; end
      endcase
      ew = (n != prev_n) && (n % (6 * P) == 0);
      check("pwm_r", int'(pwm_r), er);
      check("pwm_g", int'(pwm_g), eg);
      check("pwm_b", int'(pwm_b), eb);
      check("segment", int'(segment), seg);
      check("wrap", int'(wrap), int'(ew));
      check("dwell", int'(dwell), int'(in_dwell));
      prev_n = n;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_r"}, int'(pwm_r), F);
      check({tag, "_g"}, int'(pwm_g), 0);
      check({tag, "_b"}, int'(pwm_b), 0);
      check({tag, "_seg"}, int'(segment), 0);
      check({tag, "_wrap"}, int'(wrap), 0);
      check({tag, "_dwell"}, int'(dwell), 0);
   endtask

   task automatic cycle(input bit r);
      run = r;
      @(posedge clk);
      if (r) run_cycles++;
      @(negedge clk);
      check_model();
   endtask

   // Asynchronous pulse between edges; outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1 check_reset_state(tag);
      #1 rst = 1'b0;
      run_cycles = 0;
      prev_n     = 0;
   endtask

   function automatic int model_seg();
      return ((run_cycles / TDIV) / P) % 6;
   endfunction

   initial begin
      rst = 1'b1;
      run = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("rst_held");
      rst = 1'b0;
      #1 check_reset_state("rst_release");

      for (int i = 0; i < 20; i++) cycle(1'b0);

      for (int i = 0; i < 6 * P * TDIV + 30; i++) cycle(1'b1);

      begin
         int guard;
         guard = 0;
         while (model_seg() != 3 && guard < 1000) begin
            cycle(1'b1);
            guard++;
         end
         check("reach_seg3_timeout", int'(guard < 1000), 1);
         cycle(1'b1);
         async_reset("async_seg3");
      end

      for (int i = 0; i < 2500; i++) begin
         cycle($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) async_reset("async_rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hue_sequencer.md
Name: hue_sequencer

Overview:
- Controller that sequences the three RGB PWM duty channels around the six-segment colour wheel: red, yellow, green, cyan, blue, magenta, back to red.
- Owns the hue segment state, a step prescaler and the ramp counter.
- Drives pwm_value_r/g/b straight into three pwm instances; the top level only inverts the pwm outputs for the active-low LEDs.
- Replaces ad-hoc duty arithmetic in top with one timed, pausable sequencer.

Parameters:
PWM_INTERVAL, 1200, full-scale duty value (pwm period in clk cycles)
STEP, 1, ramp increment per tick; legal range 1..PWM_INTERVAL
TICK_DIV, 1667, clk cycles per ramp tick; legal range >=1 (1200 ticks x 6 segments x 1667 = ~1 s at 12 MHz)
DWELL_TICKS, 300, ticks held at each segment endpoint; used only with DWELL_EN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
run  in  1  1 = sequence advances; 0 = freeze everything
pwm_value_r  out  $clog2(PWM_INTERVAL+1)  red duty
pwm_value_g  out  $clog2(PWM_INTERVAL+1)  green duty
pwm_value_b  out  $clog2(PWM_INTERVAL+1)  blue duty
segment  out  3  current segment index, 0..5
wrap  out  1  one-cycle pulse when segment 5 completes
dwell  out  1  1 while holding an endpoint colour; tied 0 without DWELL_EN

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values, applied immediately on rst, including mid-operation:
  - segment=0, ramp=0, prescaler=0, dwell counter=0.
  - pwm_value_r=PWM_INTERVAL, pwm_value_g=0, pwm_value_b=0.
  - wrap=0, dwell=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while run=1.
  - tick=1 in the cycle where prescaler==TICK_DIV-1 and run=1; prescaler then returns to 0.
  - TICK_DIV=1 gives a tick on every run cycle.
- run=0: prescaler, ramp, segment and outputs all hold. On run=1 the prescaler resumes from its held count, not from 0.
- On tick, outside dwell:
  - If ramp+STEP >= PWM_INTERVAL (compare at width+1, no overflow): ramp<=0 and segment advances (5->0). wrap=1 for exactly one cycle on the 5->0 transition.
  - Otherwise ramp<=ramp+STEP.
- Channel mapping, with F=PWM_INTERVAL, up=ramp, dn=F-ramp (order r, g, b):
  - 0 R_TO_Y: F, up, 0
  - 1 Y_TO_G: dn, F, 0
  - 2 G_TO_C: 0, F, up
  - 3 C_TO_B: 0, dn, F
  - 4 B_TO_M: up, 0, F
  - 5 M_TO_R: F, 0, dn
- Output timing:
  - Outputs are registers computed from the next-state ramp/segment, so they change on the same edge as the state; no extra latency.
  - Within a segment, outputs are constant between ticks.
- Non-divisible STEP: the final partial step is skipped and the segment advances. Duty never exceeds F and never goes negative.
- Simultaneous events: rst dominates everything. A tick with run=0 is impossible by definition.

Optional Feature:
- Macro: HUE_SEQUENCER_DWELL_EN.
- When defined, the tick that ends a segment does not advance it. Instead:
  - The block enters DWELL with segment unchanged and dwell=1.
  - Outputs show the endpoint colour: rising channel=F, falling channel=0.
  - Exactly DWELL_TICKS ticks later, the block advances the segment, sets ramp=0 and clears dwell.
  - wrap pulses on that exit tick from segment 5.
- When undefined: no dwell state or counter is generated, dwell is tied 0, and DWELL_TICKS is ignored.

Decomposition:
- Package hue_seq_pkg:
  - typedef enum logic [2:0] seg_t: R_TO_Y, Y_TO_G, G_TO_C, C_TO_B, B_TO_M, M_TO_R.
  - Constant SEG_LAST = M_TO_R.
- Sub-module tick_prescaler (TICK_DIV; ports clk, rst, run, tick).
- The segment/ramp FSM and the output mapping stay in hue_sequencer.

Test Plan:
All scenarios use PWM_INTERVAL=12, STEP=3, TICK_DIV=4.
1. Reset: assert rst, release, run=0 -> r=12, g=0, b=0, segment=0, wrap=0, dwell=0, held indefinitely.
2. Ramp: run=1 from cycle 0 -> ticks at cycles 3, 7, 11, 15 -> g=3, 6, 9; at 4th tick segment=1, r=12, g=12; following ticks r=9, 6, 3.
3. Full cycle: run=1 for 24 ticks (96 cycles) -> wrap high for exactly one cycle; segment=0, r=12, g=0, b=0; each segment observed in order 0..5.
4. Pause: run=0 for 10 cycles mid-segment 2 at prescaler=2 -> all outputs frozen; after run=1 the next tick arrives 2 cycles later.
5. Async reset: pulse rst between edges while in segment 3 -> outputs return to 12/0/0 and segment=0 before the next clk edge.
6. HUE_SEQUENCER_DWELL_EN, DWELL_TICKS=2 -> at 4th tick dwell=1, segment=0, r=12, g=12; at 6th tick segment=1, dwell=0, r=12; at 7th tick r=9.
